decade_counter: RTL and testbench
=================================

Name: decade_counter

Overview:
- Free-running modulo-N counter, default decade (0..9), 4-bit output.
- Used as a timebase/prescaler stage.
- Adds a count enable, synchronous clear, parallel load and a terminal-count flag so stages can be cascaded (tc of one stage drives en of the next).

Parameters:
- WIDTH, 4, counter/output width in bits.
- MODULUS, 10, count sequence length; q cycles 0..MODULUS-1. Legal range 2..2^WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. 0 clears the counter immediately, independent of clk.
- en  input  1  count enable; tie to 1 for free-running operation.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value loaded when load=1.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational: q==MODULUS-1 && en.
- wrap  output  1  registered one-cycle pulse, high the cycle after q wraps MODULUS-1 -> 0 via counting.

Behaviour:
- Reset:
  - While reset=0: q=0, wrap=0, asynchronously; held for the whole assertion.
  - Deassertion is sampled at the next rising clk edge.
  - Reset mid-count discards state; counting restarts from 0.
- Priority at each rising edge, reset deasserted (high to low): clr > load > en > hold.
  - clr=1: q<=0, wrap<=0.
  - load=1: q<=load_val if load_val<MODULUS, else q<=0. wrap<=0.
  - en=1: if q==MODULUS-1 then q<=0 and wrap<=1; else q<=q+1 and wrap<=0.
  - en=0: q holds, wrap<=0.
- Latency: one clock from a control input to q.
- Arithmetic: unsigned, WIDTH bits.
- Illegal q: q never leaves 0..MODULUS-1. Any value >= MODULUS (e.g. after bit upset) becomes 0 on the next enabled count.
- With default parameters and en=1: q = 0,1,...,9,0,1,...; period 10 clocks.
- tc is purely combinational from q and en; it is low during reset because q=0 (MODULUS>=2).
- clr and load simultaneously: clr wins.
- No X on outputs after the first reset assertion.

Optional Feature:
- Macro DECADE_COUNTER_UPDOWN_EN.
- Defined: extra input port dn (1 bit).
  - dn=1 and en=1: q counts down and wraps 0 -> MODULUS-1.
  - When counting down, tc = (q==0 && en) and wrap pulses on the 0 -> MODULUS-1 transition.
  - dn=0 gives the up-counting behaviour described above.
  - Priority of clr/load is unchanged.
- Not defined: no dn port; counter counts up only.

Test Plan:
- Hold reset=0 for 2 clocks, then release with en=1, clr=0, load=0 -> q=0 during reset. After release q steps 1,2,...,9,0,1 on successive edges. wrap high exactly the cycle q=0 after 9. tc high when q=9.
- With q=5, drive reset low between clock edges -> q becomes 0 before the next edge and stays 0 while low. Release -> counting resumes 1,2,...
- en=1 throughout. Pulse clr at q=7 -> q=0 next edge. Pulse load with load_val=8 -> q=8, then 9, then 0 with wrap=1. Load load_val=12 -> q=0. Assert clr and load together with load_val=3 -> q=0.
- en toggled 0/1 at random -> q advances only on edges with en=1. tc never high while en=0. Compare q against a behavioural model over 400 random cycles with random short reset pulses.
- With DECADE_COUNTER_UPDOWN_EN and dn=1 from q=2 -> q=1,0,9,8. wrap pulses after the 0->9 step. tc high at q=0.

Source files
------------

// File: rtl/decade_counter.sv
// decade_counter: modulo-MODULUS counter (default 0..9) with count enable,
// synchronous clear, parallel load, a combinational terminal-count flag and
// a registered wrap pulse, so stages can be cascaded (tc -> en of next stage).
//
// Optional build macro DECADE_COUNTER_UPDOWN_EN adds a dn input. With dn=1 and
// en=1 the counter counts down, wrapping 0 -> MODULUS-1.
//
// reset is asynchronous and active low. It clears q and wrap immediately.
module decade_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`ifdef DECADE_COUNTER_UPDOWN_EN
   input  logic             dn,
`endif
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   // Last legal count value. MODULUS is also kept one bit wider, so that
   // MODULUS == 2**WIDTH can still be represented and compared against.
   localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic             count_down;
   logic [WIDTH-1:0] q_next;
   logic             wrap_next;

   // Direction select. Without the up/down option, the counter is up-only.
`ifdef DECADE_COUNTER_UPDOWN_EN
   always_comb count_down = dn;
`else
   always_comb count_down = 1'b0;
`endif

   // Next-state selection. Priority order is clr, then load, then en, then hold.
   // An out-of-range q returns to 0 on the next enabled count. This step does
   // not produce a wrap pulse.
   always_comb begin
      q_next    = q;
      wrap_next = 1'b0;
      if (clr) begin
         q_next = '0;
      end else if (load) begin
         q_next = ({1'b0, load_val} < MOD_EXT) ? load_val : '0;
      end else if (en) begin
         if ({1'b0, q} >= MOD_EXT) begin
            q_next = '0;
         end else if (count_down) begin
            if (q == '0) begin
               q_next    = Q_MAX;
               wrap_next = 1'b1;
            end else begin
               q_next = q - WIDTH'(1);
            end
         end else begin
            if (q == Q_MAX) begin
               q_next    = '0;
               wrap_next = 1'b1;
            end else begin
               q_next = q + WIDTH'(1);
            end
         end
      end
   end

   // Count and wrap registers, with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q    <= '0;
         wrap <= 1'b0;
      end else begin
         q    <= q_next;
         wrap <= wrap_next;
      end
   end

   // Terminal count. This is the value at which the next enabled count wraps.
   always_comb tc = en && (count_down ? (q == '0) : (q == Q_MAX));

endmodule

// File: tb/tb_decade_counter.sv
// Self-checking bench for decade_counter with the default parameters
// (WIDTH=4, MODULUS=10). Inputs change on the falling clock edge.
// Outputs are sampled 1 time unit after the rising edge.
module tb_decade_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic       clr = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = '0;
   logic       dn = 1'b0;
   logic [3:0] q;
   logic       tc;
   logic       wrap;

   int n_checks = 0;
   int n_fail   = 0;

   decade_counter #(.WIDTH(4), .MODULUS(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
`ifdef DECADE_COUNTER_UPDOWN_EN
      .dn       (dn),
`endif
      .q        (q),
      .tc       (tc),
      .wrap     (wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       clr;
      logic       load;
      logic [3:0] lv;
      logic [3:0] q;
      logic       wrap;
      logic       tc;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
      end
   endtask

   task automatic check_all(input string name, input int eq, input int ew, input int et);
      check({name, ".q"}, int'(q), eq);
      check({name, ".wrap"}, int'(wrap), ew);
      check({name, ".tc"}, int'(tc), et);
   endtask

   task automatic add(input logic e, input logic c, input logic l, input logic [3:0] lv,
                      input logic [3:0] eq, input logic ew, input logic et);
      vec_t v;
      v.en = e; v.clr = c; v.load = l; v.lv = lv; v.q = eq; v.wrap = ew; v.tc = et;
      vecs.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int m_q;
   int m_wrap;

   initial begin
      // Table: en clr load load_val | q wrap tc.
      // The initial reset is released at q=0.
      for (int unsigned i = 1; i <= 9; i++)
         add(1, 0, 0, 0, 4'(i), 0, (i == 9) ? 1'b1 : 1'b0);
      add(1, 0, 0, 0, 0, 1, 0);   // 9 -> 0 wrap
      for (int unsigned i = 1; i <= 7; i++)
         add(1, 0, 0, 0, 4'(i), 0, 0);
      add(1, 1, 0, 0,  0, 0, 0);  // clr at 7
      add(1, 0, 1, 8,  8, 0, 0);  // load 8
      add(1, 0, 0, 0,  9, 0, 1);
      add(1, 0, 0, 0,  0, 1, 0);  // wrap after loaded 8
      add(1, 0, 1, 12, 0, 0, 0);  // out-of-range load
      add(1, 0, 0, 0,  1, 0, 0);
      add(1, 1, 1, 3,  0, 0, 0);  // clr beats load
      add(1, 0, 1, 3,  3, 0, 0);
      add(0, 0, 0, 0,  3, 0, 0);  // hold
      add(1, 0, 1, 9,  9, 0, 1);  // load beats en, tc with en=1
      add(0, 0, 0, 0,  9, 0, 0);  // tc gated by en
      add(1, 0, 0, 0,  0, 1, 0);
      add(1, 0, 1, 15, 0, 0, 0);
      add(0, 0, 1, 0,  0, 0, 0);

      // Reset held low for two clocks.
      reset = 1'b0;
      tick();
      tick();
      check_all("reset_hold", 0, 0, 0);
      @(negedge clk);
      reset = 1'b1; en = 1'b1;

      foreach (vecs[i]) begin
         en = vecs[i].en; clr = vecs[i].clr; load = vecs[i].load; load_val = vecs[i].lv;
         tick();
         check_all($sformatf("vec%0d", i), int'(vecs[i].q), int'(vecs[i].wrap), int'(vecs[i].tc));
         @(negedge clk);
      end
      clr = 1'b0; load = 1'b0; en = 1'b1;

      // Asynchronous reset in the middle of the count: q=0 before the next edge.
      for (int unsigned i = 0; i < 5; i++) tick();
      check("async.pre_q", int'(q), 5);
      @(negedge clk);
      #2 reset = 1'b0;
      #1 check("async.immediate_q", int'(q), 0);
      tick();
      check_all("async.held", 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      check("async.resume1", int'(q), 1);
      tick();
      check("async.resume2", int'(q), 2);

      // Random en/clr/load and short reset pulses, checked against a model.
      m_q = 2; m_wrap = 0;
      for (int unsigned i = 0; i < 400; i++) begin
         @(negedge clk);
         reset    = ($urandom_range(0, 24) != 0);
         en       = 1'($urandom_range(0, 1));
         clr      = ($urandom_range(0, 15) == 0);
         load     = ($urandom_range(0, 9) == 0);
         load_val = 4'($urandom_range(0, 15));
         if (!reset) begin
            m_q = 0; m_wrap = 0;
            #1 check("rand.async_q", int'(q), 0);
         end
         @(posedge clk);
         if (!reset) begin
            m_q = 0; m_wrap = 0;
         end else if (clr) begin
            m_q = 0; m_wrap = 0;
         end else if (load) begin
            m_q = (load_val < 10) ? int'(load_val) : 0; m_wrap = 0;
         end else if (en) begin
            m_wrap = (m_q == 9) ? 1 : 0;
            m_q = (m_q + 1) % 10;
         end else begin
            m_wrap = 0;
         end
         #1;
         check("rand.q", int'(q), m_q);
         check("rand.wrap", int'(wrap), m_wrap);
         check("rand.tc", int'(tc), (en && m_q == 9) ? 1 : 0);
      end
      @(negedge clk);
      reset = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b1;

`ifdef DECADE_COUNTER_UPDOWN_EN
      // Down counting from 2: 1, 0, 9 with wrap, 8.
      load = 1'b1; load_val = 4'd2; dn = 1'b1;
      tick();
      check_all("dn.load", 2, 0, 0);
      @(negedge clk);
      load = 1'b0;
      tick();
      check_all("dn.q1", 1, 0, 0);
      tick();
      check_all("dn.q0", 0, 0, 1);
      tick();
      check_all("dn.q9", 9, 1, 0);
      tick();
      check_all("dn.q8", 8, 0, 0);
      @(negedge clk);
      dn = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
